// File: rtl/piso_shift_reg2d_pkg.sv
// Shared constants and state encoding for the 2-D parallel-in / serial-out shifter.
package piso_shift_reg2d_pkg;
    localparam int PISO_WIDTH = 4;   // bits per word
    localparam int PISO_DEPTH = 16;  // words per frame
    localparam int CNT_W      = 5;   // COUNT range 0..16

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/piso_shift_reg2d_shift_count.sv
// Loadable down-counter: words remaining in the frame plus last-word detect.
module shift_count
    import piso_shift_reg2d_pkg::*;
#(
    parameter int DEPTH = PISO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear beats load beats decrement.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (load)
            count_d = CNT_W'(DEPTH);
        else if (dec && count_q != '0)
            count_d = count_q - 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(1));
endmodule

// File: rtl/piso_shift_reg2d.sv
// 16-word parallel-load frame emitted one word per transfer, IN_15 first,
// with valid/ready handshake, synchronous flush and async-assert reset.
module piso_shift_reg2d
    import piso_shift_reg2d_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH,
    parameter int DEPTH = PISO_DEPTH   // the port list carries 16 words
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] IN_0,  input logic [WIDTH-1:0] IN_1,
    input  logic [WIDTH-1:0] IN_2,  input logic [WIDTH-1:0] IN_3,
    input  logic [WIDTH-1:0] IN_4,  input logic [WIDTH-1:0] IN_5,
    input  logic [WIDTH-1:0] IN_6,  input logic [WIDTH-1:0] IN_7,
    input  logic [WIDTH-1:0] IN_8,  input logic [WIDTH-1:0] IN_9,
    input  logic [WIDTH-1:0] IN_10, input logic [WIDTH-1:0] IN_11,
    input  logic [WIDTH-1:0] IN_12, input logic [WIDTH-1:0] IN_13,
    input  logic [WIDTH-1:0] IN_14, input logic [WIDTH-1:0] IN_15,
    input  logic             FLUSH,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT
);
    logic [15:0][WIDTH-1:0]      in_w;
    logic [1:0]                  rst_sync_q, rst_sync_d;
    logic                        rst_n_int;
    state_e                      state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                        accept, xfer, last;

    assign in_w = {IN_15, IN_14, IN_13, IN_12, IN_11, IN_10, IN_9, IN_8,
                   IN_7,  IN_6,  IN_5,  IN_4,  IN_3,  IN_2,  IN_1, IN_0};

    // Reset synchroniser: asserts immediately, releases two edges later.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Synchroniser register, cleared straight from the pin.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    // LOAD counts only when idle; flush overrides both load and transfer.
    assign accept = (state_q == ST_IDLE)  && LOAD      && !FLUSH;
    assign xfer   = (state_q == ST_SHIFT) && OUT_READY && !FLUSH;

    // Next state: idle -> shift on accepted load; back on flush or last transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)                 state_d = ST_SHIFT;
            ST_SHIFT: if (FLUSH || (xfer && last)) state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Frame storage: parallel load, or shift toward the top with zero fill so
    // the output word naturally reads 0 once the frame is drained or flushed.
    always_comb begin
        mem_d = mem_q;
        if (FLUSH)
            mem_d = '0;
        else if (accept) begin
            for (int k = 0; k < DEPTH; k++) mem_d[k] = in_w[k];
        end else if (xfer)
            mem_d = {mem_q[DEPTH-2:0], {WIDTH{1'b0}}};
    end

    // State and storage registers.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_IDLE;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
        end
    end

    shift_count #(.DEPTH(DEPTH)) u_cnt (
        .clk   (CLK),
        .rst_n (rst_n_int),
        .load  (accept),
        .dec   (xfer),
        .clr   (FLUSH),
        .count (COUNT),
        .last  (last)
    );

    assign OUT       = mem_q[DEPTH-1];
    assign OUT_VALID = (state_q == ST_SHIFT);
    assign BUSY      = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_piso_shift_reg2d.sv
// Randomised and directed bench for piso_shift_reg2d against a queue model.
module tb_piso_shift_reg2d;
    import piso_shift_reg2d_pkg::*;

    logic             CLK = 1'b0;
    logic             RESET_N, LOAD, FLUSH, OUT_READY;
    logic [3:0]       in_w [16];
    logic [3:0]       OUT;
    logic             OUT_VALID, BUSY;
    logic [CNT_W-1:0] COUNT;

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] q [$];     // words still to be emitted, front = current OUT
    logic [3:0] got [$];   // words observed on the DUT at transfers
    logic [3:0] rx [16];   // serial-in receiver, input at rx[0]

    always #5 CLK = ~CLK;

    piso_shift_reg2d dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD),
        .IN_0(in_w[0]),   .IN_1(in_w[1]),   .IN_2(in_w[2]),   .IN_3(in_w[3]),
        .IN_4(in_w[4]),   .IN_5(in_w[5]),   .IN_6(in_w[6]),   .IN_7(in_w[7]),
        .IN_8(in_w[8]),   .IN_9(in_w[9]),   .IN_10(in_w[10]), .IN_11(in_w[11]),
        .IN_12(in_w[12]), .IN_13(in_w[13]), .IN_14(in_w[14]), .IN_15(in_w[15]),
        .FLUSH(FLUSH), .OUT_READY(OUT_READY),
        .OUT(OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .COUNT(COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs with the model, drive one cycle of inputs, advance the model.
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic ld, input logic fl, input logic rdy);
        chk("out",  OUT,       (q.size() != 0) ? q[0] : 4'd0);
        chk("vld",  OUT_VALID, q.size() != 0);
        chk("busy", BUSY,      q.size() != 0);
        chk("cnt",  COUNT,     q.size());
        LOAD = ld; FLUSH = fl; OUT_READY = rdy;
        if (fl)
            q.delete();
        else if (q.size() == 0) begin
            if (ld) for (int k = 15; k >= 0; k--) q.push_back(in_w[k]);
        end else if (rdy) begin
            got.push_back(OUT);
            for (int k = 15; k > 0; k--) rx[k] = rx[k-1];
            rx[0] = OUT;
            void'(q.pop_front());
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Transfer with ready high until the model holds n words.
    task automatic drain_to(input int n);
        int guard = 0;
        while (q.size() > n && guard < 40) begin
            step(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_bound", q.size(), n);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; LOAD = 0; FLUSH = 0; OUT_READY = 0;
        q.delete();
        repeat (2) step(1'b0, 1'b0, 1'b0);
        RESET_N = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);  // synchroniser release window
    endtask

    initial begin
        int tgl;
        for (int k = 0; k < 16; k++) begin in_w[k] = 4'(k); rx[k] = 4'd0; end
        RESET_N = 1'b0; LOAD = 0; FLUSH = 0; OUT_READY = 0;
        @(negedge CLK);
        do_reset();

        // Basic frame: IN_k = k comes out 15..0 back to back.
        got.delete();
        step(1'b1, 1'b0, 1'b1);
        drain_to(0);
        chk("seq_len", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("seq", got[i], 15 - i);
        step(1'b0, 1'b0, 1'b1);   // valid low after the frame

        // Loopback into the serial-in receiver.
        for (int k = 0; k < 16; k++) in_w[k] = 4'((k * 3) & 15);
        step(1'b1, 1'b0, 1'b1);
        drain_to(0);
        for (int k = 0; k < 16; k++) chk("loop", rx[k], (k * 3) & 15);

        // Ready toggling 1,0,0,1,...: no loss or duplication.
        for (int k = 0; k < 16; k++) in_w[k] = 4'(k);
        got.delete();
        step(1'b1, 1'b0, 1'b0);
        tgl = 0;
        while (q.size() != 0 && tgl < 80) begin
            step(1'b0, 1'b0, (tgl % 3) == 0);
            tgl++;
        end
        chk("tgl_len", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("tgl_seq", got[i], 15 - i);

        // LOAD while busy (count 8 and final transfer) is ignored.
        for (int k = 0; k < 16; k++) in_w[k] = 4'(15 - k);
        step(1'b1, 1'b0, 1'b1);
        drain_to(8);
        for (int k = 0; k < 16; k++) in_w[k] = 4'd9;
        step(1'b1, 1'b0, 1'b1);
        drain_to(1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);   // idle load accepted
        chk("reload_cnt", COUNT, 16);

        // FLUSH with LOAD at count 5.
        drain_to(5);
        step(1'b1, 1'b1, 1'b1);
        chk("flush_out", OUT, 0);
        chk("flush_cnt", COUNT, 0);
        step(1'b0, 1'b0, 1'b1);

        // Reset pulsed between edges at count 10.
        step(1'b1, 1'b0, 1'b1);
        drain_to(10);
        LOAD = 0; FLUSH = 0;
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_out", OUT, 0);
        chk("arst_vld", OUT_VALID, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_cnt", COUNT, 0);
        q.delete();
        #1 RESET_N = 1'b1;
        @(negedge CLK);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        in_w[15] = 4'hA;
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_first", OUT, 4'hA);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic ld, fl, rdy;
            ld  = ($urandom_range(3) == 0);
            fl  = ($urandom_range(24) == 0);
            rdy = ($urandom_range(3) != 0);
            if (ld) for (int k = 0; k < 16; k++) in_w[k] = 4'($urandom);
            step(ld, fl, rdy);
        end
        step(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/piso_shift_reg2d.md
PISO_SHIFT_REG2D -- requirements
Module: piso_shift_reg2d

Interface
- REQ-001 Parameter WIDTH: default 4; bits per word.
- REQ-002 Parameter DEPTH: default 16; words per frame.
- REQ-003 CLK, input, 1: single clock; all state updates on rising edge.
- REQ-004 RESET_N, input, 1: asynchronous, active-low reset.
- REQ-005 LOAD, input, 1: parallel-load strobe; honoured only when BUSY=0.
- REQ-006 IN_0..IN_15, input, WIDTH each: parallel frame words, sampled on an accepted LOAD.
- REQ-007 FLUSH, input, 1: synchronous abort of the frame in progress.
- REQ-008 OUT_READY, input, 1: downstream accepts OUT this cycle.
- REQ-009 OUT, output, WIDTH: current serial word.
- REQ-010 OUT_VALID, output, 1: OUT holds a valid word.
- REQ-011 BUSY, output, 1: a frame is loaded and not fully emitted.
- REQ-012 COUNT, output, 5: words remaining in the frame, 0..16.

Function
- REQ-013 The block SHALL implement two states: IDLE (BUSY=0, OUT_VALID=0, COUNT=0) and SHIFT (BUSY=1, OUT_VALID=1, COUNT≥1).
- REQ-014 On an edge in IDLE with LOAD=1 and FLUSH=0, the block SHALL capture IN_0..IN_15, set COUNT=16, enter SHIFT, and present OUT=IN_15 with OUT_VALID=1 from that edge onward (1-cycle latency).
- REQ-015 Emission order SHALL be IN_15, IN_14, …, IN_0, so that a serial-in 4x16 register (input at OUT_0, shifting toward OUT_15) fed with the emitted words holds IN_k at OUT_k after 16 transfers.
- REQ-016 A transfer SHALL occur on an edge where OUT_VALID=1 and OUT_READY=1; it advances OUT to the next word and decrements COUNT by 1.
- REQ-017 With OUT_READY=0, OUT, OUT_VALID and COUNT SHALL hold their values unchanged.
- REQ-018 A transfer at COUNT=1 SHALL return the block to IDLE; OUT_VALID SHALL be 0 on the following cycle.
- REQ-019 LOAD SHALL be ignored while BUSY=1, including in the cycle of the final transfer; a new frame needs LOAD in a cycle with BUSY=0.
- REQ-020 FLUSH=1 SHALL force IDLE on the next edge, discarding the remaining words; FLUSH takes priority over LOAD and over a transfer in the same cycle.
- REQ-021 OUT SHALL read 0 while OUT_VALID=0.
- REQ-022 The sustained throughput SHALL be one word per cycle with OUT_READY held high; a 16-word frame occupies exactly 16 cycles of OUT_VALID.

Reset
- REQ-023 RESET_N=0 SHALL immediately, without waiting for a clock edge, force IDLE, OUT=0, OUT_VALID=0, BUSY=0, COUNT=0, and clear the frame storage to 0.
- REQ-024 Reset asserted mid-frame SHALL discard the frame; after RESET_N rises, the first edge with LOAD=1 starts a fresh frame.
- REQ-025 Reset deassertion SHALL be synchronised to CLK, so the first state change occurs no earlier than the second rising edge after RESET_N rises.

Structure
- REQ-026 WIDTH, DEPTH, the COUNT width (5) and the state encoding (IDLE, SHIFT) SHALL live in a shared package used by this block and its bench.
- REQ-027 Frame storage SHALL be a DEPTH×WIDTH register array that shifts by one word per transfer, with no per-word multiplexer tree.
- REQ-028 One sub-module, shift_count, SHALL hold the loadable down-counter driving COUNT and the last-word detect.

Verification
- REQ-029 Reset, then LOAD with IN_k=k and OUT_READY=1 -> OUT sequence 15,14,…,0 on 16 consecutive cycles; COUNT 16→1; OUT_VALID low on cycle 17.
- REQ-030 Loopback into the 4x16 serial-in register, frame IN_k=(k*3)&0xF -> after 16 transfers, the receiver's OUT_k equals IN_k for all k.
- REQ-031 OUT_READY toggling 1,0,0,1,… during a frame -> OUT and COUNT hold during low cycles; all 16 words arrive with no loss or duplicates.
- REQ-032 LOAD pulsed at COUNT=8 and in the final-transfer cycle -> both ignored; the frame completes unchanged; the next LOAD in IDLE is accepted.
- REQ-033 FLUSH asserted with LOAD at COUNT=5 -> IDLE next cycle, COUNT=0, OUT_VALID=0, OUT=0.
- REQ-034 RESET_N pulsed low between clock edges at COUNT=10 -> outputs cleared before the next edge; the next LOAD with IN_15=0xA gives OUT=0xA first.
